// File: rtl/errbit_frame_pkg.sv
// Shared framing constants, field offsets and receiver FSM states for the
// 24-bit error-bit frame (header 1,0,1 / flags / ET bits / veto bits / stop).
package errbit_frame_pkg;

  localparam int unsigned HDR_LEN      = 3;
  localparam logic [2:0]  HDR_PATTERN  = 3'b101;  // bit i is the i-th header bit on the line
  localparam int unsigned PAYLOAD_LEN  = 20;
  localparam int unsigned ET_W         = 11;
  localparam int unsigned VETO_W       = 7;
  localparam int unsigned IDX_W        = 5;

  // Payload-relative field offsets, shared with the packer.
  localparam int unsigned OFF_GOT_ET   = 0;
  localparam int unsigned OFF_GOT_VETO = 1;
  localparam int unsigned OFF_ET       = 2;
  localparam int unsigned OFF_VETO     = OFF_ET + ET_W;

  typedef enum logic [2:0] {
    ST_IDLE,
    ST_H1,
    ST_H2,
    ST_PAY,
    ST_STOP,
    ST_DONE
  } unpack_state_e;

endpackage

// File: rtl/errbit_unpacker_if.sv
// Serial frame line plus decoded frame fields between packer side and unpacker.
interface errbit_unpacker_if;
  import errbit_frame_pkg::*;

  logic              d;
  logic              dv;
  logic              got_et;
  logic              got_veto;
  logic [ET_W-1:0]   errbit_et;
  logic [VETO_W-1:0] errbit_veto;
  logic              frame_err;

  modport master (
    output d,
    input  dv, got_et, got_veto, errbit_et, errbit_veto, frame_err
  );

  modport slave (
    input  d,
    output dv, got_et, got_veto, errbit_et, errbit_veto, frame_err
  );

endinterface

// File: rtl/errbit_sat_cnt.sv
// Generic up-counter with synchronous clear that sticks at all-ones.
module errbit_sat_cnt #(
  parameter int unsigned W = 8
) (
  input  logic         clk,
  input  logic         rst_n,
  input  logic         i_clr,
  input  logic         i_inc,
  output logic [W-1:0] o_cnt
);

  logic [W-1:0] r_cnt;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_cnt <= '0;
    end else if (i_clr) begin
      r_cnt <= '0;
    end else if (i_inc && (r_cnt != '1)) begin
      r_cnt <= r_cnt + W'(1);
    end
  end

  assign o_cnt = r_cnt;

endmodule

// File: rtl/errbit_unpacker.sv
// Serial error-bit frame receiver: header detect, 20-bit payload shift, optional
// stop-bit check (ERRBIT_UNPACK_STOPCHK_EN), parallel fields with dv pulse.
module errbit_unpacker
  import errbit_frame_pkg::*;
#(
  parameter int unsigned CNT_W = 16,
  parameter int unsigned ERR_W = 8
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             LIVE,
  errbit_unpacker_if.slave bus,
  output logic [CNT_W-1:0] frame_cnt,
  output logic [ERR_W-1:0] err_cnt
);

  localparam logic [IDX_W-1:0] LAST_IDX = IDX_W'(PAYLOAD_LEN - 1);

`ifdef ERRBIT_UNPACK_STOPCHK_EN
  localparam int unsigned SHIFT_W = PAYLOAD_LEN;
`else
  localparam int unsigned SHIFT_W = PAYLOAD_LEN - 1;
`endif

  unpack_state_e          r_state, w_state_nxt;
  logic [IDX_W-1:0]       r_idx;
  logic [SHIFT_W-1:0]     r_shift;
  logic [SHIFT_W-1:0]     w_shift_nxt;
  logic [PAYLOAD_LEN-1:0] w_payload;
  logic                   w_shift_en;
  logic                   w_idx_clr;
  logic                   w_load;
  logic                   w_err;
  logic                   w_clr;

  logic                   r_dv;
  logic                   r_frame_err;
  logic                   r_got_et;
  logic                   r_got_veto;
  logic [ET_W-1:0]        r_et;
  logic [VETO_W-1:0]      r_veto;
  logic [CNT_W-1:0]       r_frame_cnt;

  // Without the stop check the fields load on the last payload bit itself, so
  // that bit is taken straight from the line and the register is one bit short.
`ifdef ERRBIT_UNPACK_STOPCHK_EN
  assign w_shift_nxt = {bus.d, r_shift[SHIFT_W-1:1]};
  assign w_payload   = r_shift;
`else
  assign w_payload   = {bus.d, r_shift};
  assign w_shift_nxt = w_payload[PAYLOAD_LEN-1:1];
`endif

  assign w_clr = ~LIVE;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state <= ST_IDLE;
    end else begin
      r_state <= w_state_nxt;
    end
  end

  always_comb begin
    w_state_nxt = r_state;
    w_shift_en  = 1'b0;
    w_idx_clr   = 1'b0;
    w_load      = 1'b0;
    w_err       = 1'b0;
    if (!LIVE) begin
      w_state_nxt = ST_IDLE;
    end else begin
      unique case (r_state)
        ST_IDLE: begin
          if (bus.d == HDR_PATTERN[0]) w_state_nxt = ST_H1;
        end
        ST_H1: begin
          if (bus.d == HDR_PATTERN[1]) w_state_nxt = ST_H2;
        end
        ST_H2: begin
          if (bus.d == HDR_PATTERN[2]) begin
            w_state_nxt = ST_PAY;
            w_idx_clr   = 1'b1;
          end else begin
            w_state_nxt = ST_IDLE;
            w_err       = 1'b1;
          end
        end
        ST_PAY: begin
          w_shift_en = 1'b1;
          if (r_idx == LAST_IDX) begin
`ifdef ERRBIT_UNPACK_STOPCHK_EN
            w_state_nxt = ST_STOP;
`else
            w_state_nxt = ST_DONE;
            w_load      = 1'b1;
`endif
          end
        end
`ifdef ERRBIT_UNPACK_STOPCHK_EN
        ST_STOP: begin
          if (!bus.d) begin
            w_state_nxt = ST_DONE;
            w_load      = 1'b1;
          end else begin
            w_state_nxt = ST_IDLE;
            w_err       = 1'b1;
          end
        end
`endif
        ST_DONE: w_state_nxt = ST_IDLE;
        default: w_state_nxt = ST_IDLE;
      endcase
    end
  end

  // Fields load on entry to DONE so they are valid in the same cycle as dv.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_idx       <= '0;
      r_shift     <= '0;
      r_dv        <= 1'b0;
      r_frame_err <= 1'b0;
      r_got_et    <= 1'b0;
      r_got_veto  <= 1'b0;
      r_et        <= '1;
      r_veto      <= '1;
      r_frame_cnt <= '0;
    end else begin
      r_dv        <= w_load;
      r_frame_err <= w_err;
      if (w_idx_clr) begin
        r_idx <= '0;
      end else if (w_shift_en) begin
        r_idx <= r_idx + IDX_W'(1);
      end
      if (w_shift_en) begin
        r_shift <= w_shift_nxt;
      end
      if (w_load) begin
        r_got_et   <= w_payload[OFF_GOT_ET];
        r_got_veto <= w_payload[OFF_GOT_VETO];
        r_et       <= w_payload[OFF_ET +: ET_W];
        r_veto     <= w_payload[OFF_VETO +: VETO_W];
      end
      if (w_clr) begin
        r_frame_cnt <= '0;
      end else if (w_load) begin
        r_frame_cnt <= r_frame_cnt + CNT_W'(1);
      end
    end
  end

  errbit_sat_cnt #(
    .W (ERR_W)
  ) u_err_cnt (
    .clk   (clk),
    .rst_n (rst_n),
    .i_clr (w_clr),
    .i_inc (w_err),
    .o_cnt (err_cnt)
  );

  assign bus.dv          = r_dv;
  assign bus.frame_err   = r_frame_err;
  assign bus.got_et      = r_got_et;
  assign bus.got_veto    = r_got_veto;
  assign bus.errbit_et   = r_et;
  assign bus.errbit_veto = r_veto;
  assign frame_cnt       = r_frame_cnt;

endmodule

// File: doc/errbit_unpacker.md
# errbit_unpacker

- Downstream receiver for the 24-bit serial error-bit frame produced by the error-bit packer: header, two presence flags, 11 ET error bits, 7 veto error bits, stop bit.
- Detects the frame on the single-bit line, shifts in the payload, checks framing, and presents the fields in parallel with a one-cycle valid pulse.
- Sits on the same `clk` domain as the packer.
- Keeps a frame counter and a saturating framing-error counter for slow control.

## Interface
Parameters:
- `CNT_W`, 16: width of `frame_cnt`.
- `ERR_W`, 8: width of `err_cnt`.

Ports:
- `clk`  in  1  system clock; all logic on rising edge.
- `rst_n`  in  1  asynchronous active-low reset.
- `LIVE`  in  1  run enable; low = synchronous abort/clear.
- `d`  in  1  serial frame input (packer `q`).
- `dv`  out  1  one-cycle pulse: new frame fields valid.
- `got_et`  out  1  ET-present flag from frame.
- `got_veto`  out  1  veto-present flag from frame.
- `errbit_et`  out  11  ET error bits.
- `errbit_veto`  out  7  veto error bits.
- `frame_err`  out  1  one-cycle pulse on header or stop-bit violation.
- `frame_cnt`  out  CNT_W  good frames since clear; wraps.
- `err_cnt`  out  ERR_W  framing errors since clear; saturates at all-ones.

## Operation
Frame order on `d`, one bit per cycle:
- bits 0–2: header 1,0,1.
- bit 3: got_et.
- bit 4: got_veto.
- bits 5–15: et[0..10], LSB first.
- bits 16–22: veto[0..6], LSB first.
- bit 23: stop = 0.

FSM states:
- IDLE: `d`=1 → H1.
- H1: `d`=0 → H2; `d`=1 → stay H1 (resync, no error).
- H2: `d`=1 → PAY, bit index reset to 0; `d`=0 → IDLE with `frame_err` pulse.
- PAY: shift 20 bits. After bit index 19 → STOP (EN build) or DONE (non-EN build).
- STOP: `d`=0 → DONE; `d`=1 → IDLE with `frame_err` pulse, fields not updated.
- DONE: load output fields from the shift register, pulse `dv`, increment `frame_cnt`, → IDLE.
  - DONE does not sample `d`. The frame's stop bit (non-EN) or the following cycle (EN) is therefore ignored.

Output fields hold their value between frames.

`LIVE`=0, checked every cycle with priority over the FSM:
- FSM → IDLE; partial frame discarded.
- `dv`=0, `frame_err`=0.
- `frame_cnt`=0, `err_cnt`=0.
- Fields keep their values.

Every `frame_err` pulse increments `err_cnt`, which saturates at all-ones.

Reset values:
- `dv`=0, `frame_err`=0, `got_et`=0, `got_veto`=0.
- `errbit_et`=11'h7FF, `errbit_veto`=7'h7F.
- `frame_cnt`=0, `err_cnt`=0.
- FSM = IDLE.

Reset asserted mid-frame: immediate return to the reset state; no `dv`.

## Timing
- Cycle T: header bit 0 (`d`=1) sampled in IDLE.
- Cycle T+22: payload bit 19 sampled.
- EN build:
  - stop bit sampled at T+23.
  - `dv` and fields valid at T+24 (FSM in DONE).
  - earliest next start bit sampled at T+25.
- Non-EN build:
  - `dv` and fields valid at T+23 (FSM in DONE).
  - earliest next start bit sampled at T+24.
- `frame_err` asserts the cycle after the offending bit is sampled (the cycle the FSM is back in IDLE).
- Fields change only in a `dv` cycle.

## Configuration
- `ERRBIT_UNPACK_STOPCHK_EN` defined: STOP state present; stop bit checked; stop bit = 1 discards the frame and pulses `frame_err`.
- Not defined: no STOP state; stop bit not checked; one cycle lower latency.

## Structure
- Shared package `errbit_frame_pkg` holds:
  - `HDR_LEN`=3, `HDR_PATTERN`=3'b101.
  - `PAYLOAD_LEN`=20, `ET_W`=11, `VETO_W`=7.
  - the FSM state enum.
  - the field bit offsets, also used by the packer.
- One natural sub-module: `errbit_sat_cnt`, a generic saturating counter with sync clear, used for `err_cnt`.
- Everything else (20-bit shift register, 5-bit bit index) is inline.

## Test plan
- Good frame, got_et=1, got_veto=1, et=11'h5A3, veto=7'h2C, stop=0:
  - EN: `dv` at T+24 with those fields.
  - non-EN: `dv` at T+23.
  - `frame_cnt`=1.
- Header 1,0,0:
  - `frame_err` pulses once, `err_cnt`=1.
  - no `dv`; fields stay at reset values 7FF/7F.
- Line held 1 for 5 cycles, then 0,1 followed by a valid payload:
  - H1 resync, no error.
  - frame decoded correctly.
- Stop bit = 1:
  - EN: `frame_err`, no `dv`.
  - non-EN: `dv` with the correct fields.
- `LIVE` dropped at payload bit 10, then reasserted and a full frame sent:
  - no `dv` for the aborted frame.
  - counters cleared; new frame decoded; `frame_cnt`=1.
- 256 consecutive bad headers:
  - `err_cnt` saturates at 255.
  - `rst_n` pulse mid-frame returns all outputs to reset values.
